// File: rtl/hsv_pipe.sv
// ============================================================================
// Module : hsv_pipe
// Brief  : 3-stage streaming RGB->HSV converter with an HSV colour-key mask.
//          Define HSV_STATS_EN to add per-frame match count and centroid sums.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hsv_pipe #(
  parameter  int W  = 8,
  parameter  int XW = 10,
  parameter  int YW = 9,
  parameter  int CW = 19,
  localparam int HW = W + 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic                 in_eol,
  input  logic [W-1:0]         R,
  input  logic [W-1:0]         G,
  input  logic [W-1:0]         B,
  input  logic signed [HW-1:0] h_lo,
  input  logic signed [HW-1:0] h_hi,
  input  logic [W-1:0]         s_min,
  input  logic [W-1:0]         v_min,
  output logic                 out_valid,
  output logic                 out_sof,
  output logic                 out_eol,
  output logic signed [HW-1:0] H_o,
  output logic [W-1:0]         S_o,
  output logic [W-1:0]         V_o,
  output logic                 mask_o,
  output logic                 stat_valid,
  output logic [CW-1:0]        stat_count,
  output logic [CW+XW-1:0]     stat_sum_x,
  output logic [CW+YW-1:0]     stat_sum_y
);

  localparam logic [1:0] c_BR_ZERO = 2'd0;
  localparam logic [1:0] c_BR_R    = 2'd1;
  localparam logic [1:0] c_BR_G    = 2'd2;
  localparam logic [1:0] c_BR_B    = 2'd3;

  // ---------------- stage 1: input register ----------------
  logic [W-1:0] r_s1_r, r_s1_g, r_s1_b;
  logic         r_s1_valid, r_s1_sof, r_s1_eol;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_r     <= '0;
      r_s1_g     <= '0;
      r_s1_b     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_eol   <= 1'b0;
    end else if (!hold) begin
      r_s1_r     <= R;
      r_s1_g     <= G;
      r_s1_b     <= B;
      r_s1_valid <= in_valid;
      r_s1_sof   <= in_sof & in_valid;
      r_s1_eol   <= in_eol & in_valid;
    end
  end

  // ---------------- stage 2: max/min and hue branch ----------------
  logic [W-1:0] w_max, w_min;
  logic [1:0]   w_branch;

  always_comb begin
    w_max = r_s1_r;
    if (r_s1_g > w_max) w_max = r_s1_g;
    if (r_s1_b > w_max) w_max = r_s1_b;
    w_min = r_s1_r;
    if (r_s1_g < w_min) w_min = r_s1_g;
    if (r_s1_b < w_min) w_min = r_s1_b;
    // Equal maxima resolve in R, G, B order.
    if (w_max == '0)          w_branch = c_BR_ZERO;
    else if (w_max == r_s1_r) w_branch = c_BR_R;
    else if (w_max == r_s1_g) w_branch = c_BR_G;
    else                      w_branch = c_BR_B;
  end

  logic [W-1:0] r_s2_r, r_s2_g, r_s2_b, r_s2_max, r_s2_diff;
  logic [1:0]   r_s2_branch;
  logic         r_s2_valid, r_s2_sof, r_s2_eol;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_r      <= '0;
      r_s2_g      <= '0;
      r_s2_b      <= '0;
      r_s2_max    <= '0;
      r_s2_diff   <= '0;
      r_s2_branch <= c_BR_ZERO;
      r_s2_valid  <= 1'b0;
      r_s2_sof    <= 1'b0;
      r_s2_eol    <= 1'b0;
    end else if (!hold) begin
      r_s2_r      <= r_s1_r;
      r_s2_g      <= r_s1_g;
      r_s2_b      <= r_s1_b;
      r_s2_max    <= w_max;
      r_s2_diff   <= w_max - w_min;
      r_s2_branch <= w_branch;
      r_s2_valid  <= r_s1_valid;
      r_s2_sof    <= r_s1_sof;
      r_s2_eol    <= r_s1_eol;
    end
  end

  // ---------------- stage 3: hue, key mask, output register ----------------
  logic signed [HW-1:0] w_re, w_ge, w_be, w_de, w_hue;
  logic                 w_hue_ok, w_mask;

  always_comb begin
    w_re = {{(HW-W){1'b0}}, r_s2_r};
    w_ge = {{(HW-W){1'b0}}, r_s2_g};
    w_be = {{(HW-W){1'b0}}, r_s2_b};
    w_de = {{(HW-W){1'b0}}, r_s2_diff};
    case (r_s2_branch)
      c_BR_R:  w_hue = w_ge - w_be;
      c_BR_G:  w_hue = (w_de <<< 1) + w_be - w_re;
      c_BR_B:  w_hue = (w_de <<< 2) + w_re - w_ge;
      default: w_hue = '0;
    endcase
    // An inverted window (h_lo > h_hi) wraps around the hue circle.
    if (h_lo <= h_hi) w_hue_ok = (w_hue >= h_lo) && (w_hue <= h_hi);
    else              w_hue_ok = (w_hue >= h_lo) || (w_hue <= h_hi);
    w_mask = r_s2_valid && w_hue_ok && (r_s2_diff >= s_min) && (r_s2_max >= v_min);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      H_o       <= '0;
      S_o       <= '0;
      V_o       <= '0;
      mask_o    <= 1'b0;
    end else if (!hold) begin
      out_valid <= r_s2_valid;
      out_sof   <= r_s2_sof;
      out_eol   <= r_s2_eol;
      H_o       <= w_hue;
      S_o       <= r_s2_diff;
      V_o       <= r_s2_max;
      mask_o    <= w_mask;
    end
  end

`ifdef HSV_STATS_EN
  // ---------------- per-frame match statistics ----------------
  localparam int SXW = CW + XW;
  localparam int SYW = CW + YW;

  logic [XW-1:0]  r_x, w_x_cur;
  logic [YW-1:0]  r_y, w_y_cur;
  logic [CW-1:0]  r_acc_cnt, w_cnt_base, w_cnt_nxt;
  logic [SXW-1:0] r_acc_sx, w_sx_base, w_sx_nxt;
  logic [SYW-1:0] r_acc_sy, w_sy_base, w_sy_nxt;
  logic [CW:0]    w_cnt_sum;
  logic [SXW:0]   w_sx_sum;
  logic [SYW:0]   w_sy_sum;
  logic           r_seen;

  // A sof pixel starts from zero so it contributes to the new frame only.
  always_comb begin
    w_x_cur    = out_sof ? '0 : r_x;
    w_y_cur    = out_sof ? '0 : r_y;
    w_cnt_base = out_sof ? '0 : r_acc_cnt;
    w_sx_base  = out_sof ? '0 : r_acc_sx;
    w_sy_base  = out_sof ? '0 : r_acc_sy;
    w_cnt_sum  = {1'b0, w_cnt_base} + {{CW{1'b0}}, mask_o};
    w_sx_sum   = {1'b0, w_sx_base} + (mask_o ? {{(CW+1){1'b0}}, w_x_cur} : '0);
    w_sy_sum   = {1'b0, w_sy_base} + (mask_o ? {{(CW+1){1'b0}}, w_y_cur} : '0);
    w_cnt_nxt  = w_cnt_sum[CW]  ? '1 : w_cnt_sum[CW-1:0];
    w_sx_nxt   = w_sx_sum[SXW]  ? '1 : w_sx_sum[SXW-1:0];
    w_sy_nxt   = w_sy_sum[SYW]  ? '1 : w_sy_sum[SYW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_acc_cnt  <= '0;
      r_acc_sx   <= '0;
      r_acc_sy   <= '0;
      r_seen     <= 1'b0;
      stat_valid <= 1'b0;
      stat_count <= '0;
      stat_sum_x <= '0;
      stat_sum_y <= '0;
    end else if (!hold) begin
      stat_valid <= 1'b0;
      if (out_valid) begin
        r_acc_cnt <= w_cnt_nxt;
        r_acc_sx  <= w_sx_nxt;
        r_acc_sy  <= w_sy_nxt;
        if (out_eol) begin
          r_x <= '0;
          r_y <= w_y_cur + YW'(1);
        end else begin
          r_x <= w_x_cur + XW'(1);
          r_y <= w_y_cur;
        end
        if (out_sof) begin
          stat_count <= r_acc_cnt;
          stat_sum_x <= r_acc_sx;
          stat_sum_y <= r_acc_sy;
          stat_valid <= r_seen;
          r_seen     <= 1'b1;
        end
      end
    end
  end
`else
  assign stat_valid = 1'b0;
  assign stat_count = '0;
  assign stat_sum_x = '0;
  assign stat_sum_y = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hsv_pipe.sv
// ============================================================================
// Module : tb_hsv_pipe
// Brief  : Directed self-checking bench for hsv_pipe (W=8 defaults).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hsv_pipe;
  localparam int W  = 8;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int CW = 19;
  localparam int HW = W + 4;
`ifdef HSV_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 hold = 1'b0;
  logic                 in_valid = 1'b0, in_sof = 1'b0, in_eol = 1'b0;
  logic [W-1:0]         R = '0, G = '0, B = '0;
  logic signed [HW-1:0] h_lo = 12'sd1000, h_hi = 12'sd60;
  logic [W-1:0]         s_min = 8'd20, v_min = 8'd20;
  logic                 out_valid, out_sof, out_eol, mask_o, stat_valid;
  logic signed [HW-1:0] H_o;
  logic [W-1:0]         S_o, V_o;
  logic [CW-1:0]        stat_count;
  logic [CW+XW-1:0]     stat_sum_x;
  logic [CW+YW-1:0]     stat_sum_y;

  hsv_pipe #(.W(W), .XW(XW), .YW(YW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
    .R(R), .G(G), .B(B),
    .h_lo(h_lo), .h_hi(h_hi), .s_min(s_min), .v_min(v_min),
    .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol),
    .H_o(H_o), .S_o(S_o), .V_o(V_o), .mask_o(mask_o),
    .stat_valid(stat_valid), .stat_count(stat_count),
    .stat_sum_x(stat_sum_x), .stat_sum_y(stat_sum_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; bit sof; bit eol;
    int r; int g; int b;
    int h; int s; int vv; bit m;
  } px_t;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     sv_pulses = 0;
  longint sv_cnt = 0, sv_sx = 0, sv_sy = 0;
  px_t    pipe[3];
  px_t    vec[12];

  function automatic px_t px(int r, int g, int b, int h, int s, int vv, bit m, bit sof, bit eol);
    px_t p;
    p.v = 1'b1; p.sof = sof; p.eol = eol;
    p.r = r; p.g = g; p.b = b; p.h = h; p.s = s; p.vv = vv; p.m = m;
    return p;
  endfunction

  // Idle slot carrying garbage data and sidebands that must not leak out.
  function automatic px_t idle();
    px_t p;
    p = px(200, 100, 50, 0, 0, 0, 1'b0, 1'b1, 1'b1);
    p.v = 1'b0;
    return p;
  endfunction

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_out(input px_t e);
    if (e.v) begin
      check_eq("out_valid", longint'(out_valid), 1);
      check_eq("H", longint'(H_o), longint'(e.h));
      check_eq("S", longint'(S_o), longint'(e.s));
      check_eq("V", longint'(V_o), longint'(e.vv));
      check_eq("mask", longint'(mask_o), longint'(e.m));
      check_eq("out_sof", longint'(out_sof), longint'(e.sof));
      check_eq("out_eol", longint'(out_eol), longint'(e.eol));
    end else begin
      check_eq("idle_valid", longint'(out_valid), 0);
      check_eq("idle_mask", longint'(mask_o), 0);
      check_eq("idle_sof", longint'(out_sof), 0);
      check_eq("idle_eol", longint'(out_eol), 0);
    end
  endtask

  // Expected outputs travel through a 3-deep delay line that only advances on
  // non-held clocks.
  task automatic step(input px_t p, input bit h);
    in_valid = p.v; in_sof = p.sof; in_eol = p.eol;
    R = W'(p.r); G = W'(p.g); B = W'(p.b);
    hold = h;
    @(posedge clk); #1;
    if (!h) begin
      pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = p;
      if (stat_valid) begin
        sv_pulses++;
        sv_cnt = longint'(stat_count);
        sv_sx  = longint'(stat_sum_x);
        sv_sy  = longint'(stat_sum_y);
      end
    end
    check_out(pipe[2]);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, longint'(out_valid), 0);
    check_eq({tag, "_sof"}, longint'(out_sof), 0);
    check_eq({tag, "_eol"}, longint'(out_eol), 0);
    check_eq({tag, "_H"}, longint'(H_o), 0);
    check_eq({tag, "_S"}, longint'(S_o), 0);
    check_eq({tag, "_V"}, longint'(V_o), 0);
    check_eq({tag, "_mask"}, longint'(mask_o), 0);
    check_eq({tag, "_stat_valid"}, longint'(stat_valid), 0);
    check_eq({tag, "_stat_count"}, longint'(stat_count), 0);
    check_eq({tag, "_stat_sum_x"}, longint'(stat_sum_x), 0);
    check_eq({tag, "_stat_sum_y"}, longint'(stat_sum_y), 0);
  endtask

  task automatic send_frame();
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 4; x++) begin
        bit hit, sof, eol;
        hit = (x == 1 && y == 0) || (x == 3 && y == 1);
        sof = (x == 0 && y == 0);
        eol = (x == 3);
        if (hit) step(px(200, 100, 50, 50, 150, 200, 1'b1, sof, eol), 1'b0);
        else     step(px(0, 0, 0, 0, 0, 0, 1'b0, sof, eol), 1'b0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int i;
    int base;
    for (int k = 0; k < 3; k++) pipe[k] = idle();

    // Window is the wrapping one: h_lo=1000, h_hi=60, s_min=v_min=20.
    vec[0]  = px(200, 100,  50,   50, 150, 200, 1'b1, 1'b0, 1'b0);
    vec[1]  = px( 10, 100,  40,  210,  90, 100, 1'b0, 1'b0, 1'b0);
    vec[2]  = px(  0,   0, 255, 1020, 255, 255, 1'b1, 1'b0, 1'b0);
    vec[3]  = px( 77,  77,  77,    0,   0,  77, 1'b0, 1'b0, 1'b0);
    vec[4]  = px(  0,   0,   0,    0,   0,   0, 1'b0, 1'b0, 1'b0);
    vec[5]  = px(100,  95,  90,    5,  10, 100, 1'b0, 1'b0, 1'b0);
    vec[6]  = px(100,  50,  90,  -40,  50, 100, 1'b1, 1'b0, 1'b0);
    vec[7]  = px(  0,   0, 250, 1000, 250, 250, 1'b1, 1'b0, 1'b0);
    vec[8]  = px(100, 100,   0,  100, 100, 100, 1'b0, 1'b0, 1'b0);
    vec[9]  = px(  0, 100, 100,  300, 100, 100, 1'b0, 1'b0, 1'b0);
    vec[10] = px(  0,  30,   0,   60,  30,  30, 1'b1, 1'b0, 1'b0);
    vec[11] = px( 40,  20,  20,    0,  20,  40, 1'b1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Directed stream with a 5-cycle hold in the middle.
    i = 0;
    for (int cyc = 0; cyc < 40 && i < 12; cyc++) begin
      bit h;
      h = (cyc >= 4 && cyc < 9);
      step(vec[i], h);
      if (!h) i++;
    end
    check_eq("stream_consumed", longint'(i), 12);
    repeat (3) step(idle(), 1'b0);

    // Non-wrapping window.
    h_lo = 12'sd0; h_hi = 12'sd100;
    step(px(200, 100,  50,  50, 150, 200, 1'b1, 1'b0, 1'b0), 1'b0);
    step(px( 10, 100,  40, 210,  90, 100, 1'b0, 1'b0, 1'b0), 1'b0);
    step(px(100,  50,  90, -40,  50, 100, 1'b0, 1'b0, 1'b0), 1'b0);
    step(px(100, 100,   0, 100, 100, 100, 1'b1, 1'b0, 1'b0), 1'b0);
    repeat (3) step(idle(), 1'b0);
    h_lo = 12'sd1000; h_hi = 12'sd60;

    // Two 4x2 frames; only the second sof reports the first frame.
    base = sv_pulses;
    send_frame();
    send_frame();
    repeat (4) step(idle(), 1'b0);
    check_eq("stat_pulses", longint'(sv_pulses - base), STATS ? 1 : 0);
    check_eq("stat_count_pulse", sv_cnt, STATS ? 2 : 0);
    check_eq("stat_sum_x_pulse", sv_sx, STATS ? 4 : 0);
    check_eq("stat_sum_y_pulse", sv_sy, STATS ? 1 : 0);
    check_eq("stat_count_hold", longint'(stat_count), STATS ? 2 : 0);

    // Mid-frame reset for one clock.
    step(px(200, 100, 50, 50, 150, 200, 1'b1, 1'b1, 1'b0), 1'b0);
    step(px(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0), 1'b0);
    rst_n = 1'b0; in_valid = 1'b0; hold = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) pipe[k] = idle();
    check_all_zero("midrst");
    rst_n = 1'b1;

    base = sv_pulses;
    send_frame();
    repeat (4) step(idle(), 1'b0);
    check_eq("post_rst_no_pulse", longint'(sv_pulses - base), 0);
    step(px(0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0), 1'b0);
    repeat (4) step(idle(), 1'b0);
    check_eq("post_rst_pulse", longint'(sv_pulses - base), STATS ? 1 : 0);
    check_eq("post_rst_count", longint'(stat_count), STATS ? 2 : 0);
    check_eq("post_rst_sum_x", longint'(stat_sum_x), STATS ? 4 : 0);
    check_eq("post_rst_sum_y", longint'(stat_sum_y), STATS ? 1 : 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
